// File: rtl/line_mem_responder.sv
`timescale 1ns/1ps
// Line-granular main-memory responder: serves whole-line reads/writes from a word-wide block RAM.
// Latency: read done at T+WAIT_CYCLES+BEATS+2, write done at T+WAIT_CYCLES+BEATS+1 (T = accept cycle).
// Backpressure: one request at a time; enables are levels held until done, new work accepted only in Idle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   memAddr           request address; line offset bits and bits above the line index are ignored
//   memReadEnable     read request level (wins over a simultaneous write)
//   memWriteEnable    write request level
//   memWriteValue     line to write, byte 0 in bits [7:0]
//   memReadDone       one-cycle pulse, memReadValue valid in the same cycle
//   memWriteDone      one-cycle pulse, line committed to RAM
//   memReadValue      last line read, held between reads
//   busy              high whenever an operation is in flight
module line_mem_responder #(
    parameter int LINE_SIZE        = 8,
    parameter int BEAT_SIZE        = 4,
    parameter int LINE_INDEX_WIDTH = 10,
    parameter int ADDR_WIDTH       = 34,
    parameter int WAIT_CYCLES      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_WIDTH-1:0]    memAddr,
    input  logic                     memReadEnable,
    input  logic                     memWriteEnable,
    input  logic [8*LINE_SIZE-1:0]   memWriteValue,
    output logic                     memReadDone,
    output logic                     memWriteDone,
    output logic [8*LINE_SIZE-1:0]   memReadValue,
    output logic                     busy
);

    localparam int BEATS           = LINE_SIZE / BEAT_SIZE;
    localparam int OFFSET_WIDTH    = $clog2(LINE_SIZE);
    localparam int LINE_WIDTH      = 8 * LINE_SIZE;
    localparam int BEAT_WIDTH      = 8 * BEAT_SIZE;
    localparam int BEAT_SHIFT      = $clog2(BEATS);
    localparam int WORD_ADDR_WIDTH = LINE_INDEX_WIDTH + BEAT_SHIFT;
    localparam int RAM_WORDS       = 1 << WORD_ADDR_WIDTH;
    // Beat counter must reach BEATS: the read phase has one extra cycle to
    // collect the last word out of the RAM's output register.
    localparam int BEAT_CNT_WIDTH  = $clog2(BEATS + 1);
    localparam int WAIT_CNT_WIDTH  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_WRITE,
        S_RESPOND
    } state_t;

    state_t                        state;
    logic                          op_read;
    logic [LINE_INDEX_WIDTH-1:0]   line_idx;
    logic [LINE_WIDTH-1:0]         wline;
    logic [LINE_WIDTH-1:0]         rbuf;
    logic [LINE_WIDTH-1:0]         rbuf_next;
    logic [BEAT_CNT_WIDTH-1:0]     beat_cnt;
    logic [WAIT_CNT_WIDTH-1:0]     wait_cnt;

    logic [WORD_ADDR_WIDTH-1:0]    ram_addr;
    logic                          ram_we;
    logic [BEAT_WIDTH-1:0]         ram_wdata;
    logic [BEAT_WIDTH-1:0]         ram_q;
    logic [BEAT_WIDTH-1:0]         ram [0:RAM_WORDS-1];

    // Only the line index field of the address matters; the rest is
    // deliberately dropped so lines alias modulo the RAM size.
    logic addr_unused;
    assign addr_unused = ^memAddr;

    // Word address {index, beat}. In the final read cycle beat_cnt == BEATS
    // and the address is garbage, but that RAM output is never captured.
    always_comb begin
        ram_addr = (WORD_ADDR_WIDTH'(line_idx) << BEAT_SHIFT) | WORD_ADDR_WIDTH'(beat_cnt);
    end

    // A reset in the same cycle as a write beat suppresses that beat, so an
    // abandoned write leaves only the beats committed before the reset.
    assign ram_we = (state == S_WRITE) && !rst;

    always_comb begin
        ram_wdata = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (beat_cnt == BEAT_CNT_WIDTH'(i)) begin
                ram_wdata = wline[i*BEAT_WIDTH +: BEAT_WIDTH];
            end
        end
    end

    // Word k appears on ram_q one cycle after its address, i.e. when
    // beat_cnt == k+1; merge it into the line buffer at that point.
    always_comb begin
        rbuf_next = rbuf;
        for (int i = 0; i < BEATS; i++) begin
            if ((state == S_READ) && (beat_cnt == BEAT_CNT_WIDTH'(i + 1))) begin
                rbuf_next[i*BEAT_WIDTH +: BEAT_WIDTH] = ram_q;
            end
        end
    end

    // Backing RAM: synchronous read, one-cycle latency, contents not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr] <= ram_wdata;
        end
        ram_q <= ram[ram_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            op_read      <= 1'b0;
            beat_cnt     <= '0;
            wait_cnt     <= '0;
            memReadDone  <= 1'b0;
            memWriteDone <= 1'b0;
            memReadValue <= '0;
            busy         <= 1'b0;
        end else begin
            memReadDone  <= 1'b0;
            memWriteDone <= 1'b0;
            case (state)
                S_IDLE: begin
                    beat_cnt <= '0;
                    wait_cnt <= '0;
                    if (memReadEnable || memWriteEnable) begin
                        // Read wins; a concurrent write stays pending on
                        // its held enable and is taken on a later Idle cycle.
                        op_read  <= memReadEnable;
                        line_idx <= memAddr[OFFSET_WIDTH+LINE_INDEX_WIDTH-1:OFFSET_WIDTH];
                        if (!memReadEnable) begin
                            wline <= memWriteValue;
                        end
                        busy <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state <= S_WAIT;
                        end else if (memReadEnable) begin
                            state <= S_READ;
                        end else begin
                            state <= S_WRITE;
                        end
                    end
                end

                S_WAIT: begin
                    if (wait_cnt == WAIT_CNT_WIDTH'(WAIT_CYCLES - 1)) begin
                        wait_cnt <= '0;
                        state    <= op_read ? S_READ : S_WRITE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_CNT_WIDTH'(1);
                    end
                end

                S_READ: begin
                    rbuf <= rbuf_next;
                    if (beat_cnt == BEAT_CNT_WIDTH'(BEATS)) begin
                        // Publish the completed line together with the done
                        // pulse; both become visible in the Respond cycle.
                        memReadValue <= rbuf_next;
                        memReadDone  <= 1'b1;
                        state        <= S_RESPOND;
                    end else begin
                        beat_cnt <= beat_cnt + BEAT_CNT_WIDTH'(1);
                    end
                end

                S_WRITE: begin
                    if (beat_cnt == BEAT_CNT_WIDTH'(BEATS - 1)) begin
                        memWriteDone <= 1'b1;
                        state        <= S_RESPOND;
                    end else begin
                        beat_cnt <= beat_cnt + BEAT_CNT_WIDTH'(1);
                    end
                end

                S_RESPOND: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Memory-side responder for the line-granular cache memory interface driven by the data and instruction caches. That interface carries an address, read/write enables, a write line, per-direction done pulses and a read line.
- Serves whole-line reads and writes from an internal word-wide block RAM, moving each line in LINE_SIZE/BEAT_SIZE sequential beats after a programmable number of wait cycles.
- Used as the simulation and FPGA main-memory model behind the L1 caches.

Parameters:
- LINE_SIZE, 8: bytes per cache line; power of two.
- BEAT_SIZE, 4: bytes per backing-RAM word; power of two; must divide LINE_SIZE.
- LINE_INDEX_WIDTH, 10: log2 of the number of lines held by the backing RAM.
- ADDR_WIDTH, 34: physical address width (paddr_t).
- WAIT_CYCLES, 2: fixed wait cycles inserted before the first beat; 0 is legal.
- Derived: BEATS = LINE_SIZE/BEAT_SIZE; OFFSET_WIDTH = log2(LINE_SIZE); LINE_WIDTH = 8*LINE_SIZE.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- memAddr, in, ADDR_WIDTH: request address. Low OFFSET_WIDTH bits are ignored.
- memReadEnable, in, 1: read request; level, held by the initiator until memReadDone.
- memWriteEnable, in, 1: write request; level, held by the initiator until memWriteDone.
- memWriteValue, in, LINE_WIDTH: line to write. Byte 0 is bits [7:0].
- memReadDone, out, 1: one-cycle pulse; memReadValue is valid in the same cycle.
- memWriteDone, out, 1: one-cycle pulse; the write is complete in the backing RAM.
- memReadValue, out, LINE_WIDTH: last line read; registered.
- busy, out, 1: high in every state except Idle.

Behaviour:
- Reset: state Idle, beat counter 0, wait counter 0, memReadValue 0, both done outputs 0, busy 0. Backing RAM contents are not reset.
- Reset mid-operation: the operation is abandoned, no done pulse is issued and no further RAM writes occur. Beats already written remain in RAM.
- States: Idle, Wait, Read, Write, Respond.
- Idle:
  - If memReadEnable, latch line index memAddr[OFFSET_WIDTH+LINE_INDEX_WIDTH-1:OFFSET_WIDTH] and set op=read.
  - Else if memWriteEnable, latch the same index, latch memWriteValue and set op=write.
  - Read has priority when both enables are high. The write stays pending and is accepted on a later Idle cycle.
  - Next state: Wait if WAIT_CYCLES>0, else Read or Write.
- Wait: count WAIT_CYCLES cycles, then go to Read or Write.
- Address aliasing: upper address bits above the line index are ignored, so addresses wrap modulo 2^LINE_INDEX_WIDTH lines.
- Read:
  - Lasts BEATS+1 cycles.
  - Cycle k (k<BEATS) presents RAM word address {index, k}.
  - RAM read latency is 1 cycle; word k is captured into line buffer bytes [k*BEAT_SIZE +: BEAT_SIZE] in cycle k+1.
  - Then go to Respond.
- Write:
  - Lasts BEATS cycles.
  - Cycle k writes latched bytes [k*BEAT_SIZE +: BEAT_SIZE] to word {index, k}.
  - Then go to Respond.
- Respond:
  - Lasts 1 cycle.
  - memReadDone=1 (op=read, with memReadValue updated from the buffer in the same cycle) or memWriteDone=1 (op=write).
  - Then go to Idle.
- Latency, with request first seen high in Idle at cycle T:
  - Read: done at T+WAIT_CYCLES+BEATS+2.
  - Write: done at T+WAIT_CYCLES+BEATS+1.
- Throughput: a new request is accepted no earlier than the cycle after Respond. The initiator drops its enable the cycle after done, so no request is double-serviced.
- Input changes after acceptance (address, data, enable drop) are ignored. The operation completes and pulses done even if the enable is withdrawn.
- memReadValue holds its value between reads; a write never alters it.
- Read-after-write to the same line returns the new data.

Test Plan:
- Reset then idle:
  - Stimulus: rst high 3 cycles, then idle 10 cycles.
  - Required: both done outputs 0, busy 0, memReadValue 0 throughout.
- Write then read (defaults):
  - Stimulus: write addr 0x40 with 0x0123456789ABCDEF, then read 0x47.
  - Required: memWriteDone exactly 5 cycles after acceptance; memReadDone exactly 6 cycles after acceptance with memReadValue=0x0123456789ABCDEF.
- Aliasing (LINE_INDEX_WIDTH=10, LINE_SIZE=8):
  - Stimulus: write 0x2000 with 0xAA..AA, then read 0x0.
  - Required: read returns 0xAA..AA.
- Simultaneous enables:
  - Stimulus: read and write enables raised in the same cycle on different lines.
  - Required: memReadDone first, returning the old data; then the write is serviced with memWriteDone.
- Reset mid-write:
  - Stimulus: assert rst during Write beat 1 (BEATS=2).
  - Required: no memWriteDone; a subsequent read shows beat 0 updated and beat 1 unchanged.
- WAIT_CYCLES=0, BEATS=4 (LINE_SIZE=16, BEAT_SIZE=4):
  - Stimulus: back-to-back reads.
  - Required: each memReadDone exactly 6 cycles after its acceptance; busy low for exactly 1 cycle between operations.
